// File: rtl/tetris_pkg.sv
// Shared types and board geometry for the piece stamping logic.
package tetris_pkg;

  typedef logic [2:0] cell_t;
  localparam cell_t CELL_EMPTY = 3'b000;

  localparam int SHAPE_SIZE = 4;
  localparam int BOARD_W    = 10;
  localparam int BOARD_H    = 20;
  localparam int ADDR_W     = $clog2(BOARD_W * BOARD_H);
  localparam int CELLS      = SHAPE_SIZE * SHAPE_SIZE;
  localparam int IDX_W      = $clog2(CELLS);
  localparam int COL_W      = $clog2(SHAPE_SIZE);
  localparam int GRID_W     = 3 * CELLS;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CHECK       = 3'd1,
    CHECK_DRAIN = 3'd2,
    WRITE       = 3'd3,
    DONE        = 3'd4
  } state_t;

  function automatic cell_t grid_cell(input logic [GRID_W-1:0] grid, input logic [IDX_W-1:0] idx);
    return grid[int'(idx) * 3 +: 3];
  endfunction

endpackage

// File: rtl/cell_locate.sv
// Maps a grid index at a signed piece origin onto the board: bounds flags and RAM address.
module cell_locate
  import tetris_pkg::*;
(
  input  logic [4:0]        pos_x,
  input  logic [5:0]        pos_y,
  input  logic [IDX_W-1:0]  idx,
  output logic              in_bounds,
  output logic              above_top,
  output logic [ADDR_W-1:0] addr
);

  logic signed [6:0] x_s;
  logic signed [6:0] y_s;
  int unsigned       addr_wide;

  // Rows above the board count as in bounds so spawning pieces can poke out of the top.
  always_comb begin
    x_s       = $signed({{2{pos_x[4]}}, pos_x}) + $signed({{(7-COL_W){1'b0}}, idx[COL_W-1:0]});
    y_s       = $signed({pos_y[5], pos_y}) + $signed({{(7-(IDX_W-COL_W)){1'b0}}, idx[IDX_W-1:COL_W]});
    above_top = y_s[6];
    in_bounds = !x_s[6] && (x_s < $signed(7'(BOARD_W))) && (y_s < $signed(7'(BOARD_H)));
    addr_wide = int'(y_s[5:0]) * BOARD_W + int'(x_s[5:0]);
    if (in_bounds && !above_top) begin
      addr = ADDR_W'(addr_wide);
    end else begin
      addr = {ADDR_W{1'b0}};
    end
  end

endmodule

// File: rtl/shape_stamp.sv
// Checks a 4x4 piece grid against the board RAM and, in commit mode, writes it in.
module shape_stamp
  import tetris_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              commit,
  input  logic [GRID_W-1:0] shape_in,
  input  logic [4:0]        pos_x,
  input  logic [5:0]        pos_y,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              collision
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GRID_W-1:0] shape_q, shape_d;
  logic [4:0]        pos_x_q, pos_x_d;
  logic [5:0]        pos_y_q, pos_y_d;
  logic              commit_q, commit_d;
  logic              collision_q, collision_d;
  logic              rd_pend_q, rd_pend_d;

  cell_t             cell_s;
  logic              full_s;
  logic              in_bounds_s;
  logic              above_top_s;
  logic [ADDR_W-1:0] addr_s;

  cell_locate u_locate (
    .pos_x     (pos_x_q),
    .pos_y     (pos_y_q),
    .idx       (idx_q),
    .in_bounds (in_bounds_s),
    .above_top (above_top_s),
    .addr      (addr_s)
  );

  assign cell_s = grid_cell(shape_q, idx_q);
  assign full_s = (cell_s != CELL_EMPTY);

  // State register and operation context.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= {IDX_W{1'b0}};
      shape_q     <= {GRID_W{1'b0}};
      pos_x_q     <= 5'd0;
      pos_y_q     <= 6'd0;
      commit_q    <= 1'b0;
      collision_q <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shape_q     <= shape_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      commit_q    <= commit_d;
      collision_q <= collision_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  // Next state; a read issued last cycle is resolved here against rd_data.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shape_d     = shape_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    commit_d    = commit_q;
    rd_pend_d   = 1'b0;
    collision_d = collision_q | (rd_pend_q && (rd_data != CELL_EMPTY));
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = CHECK;
          idx_d       = {IDX_W{1'b0}};
          shape_d     = shape_in;
          pos_x_d     = pos_x;
          pos_y_d     = pos_y;
          commit_d    = commit;
          collision_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        idx_d = idx_q + 4'd1;
        if (full_s && !in_bounds_s) begin
          collision_d = 1'b1;
        end else if (full_s && !above_top_s) begin
          rd_pend_d = 1'b1;
        end else begin
          rd_pend_d = 1'b0;
        end
        if (idx_q == 4'd15) begin
          state_d = CHECK_DRAIN;
        end else begin
          state_d = CHECK;
        end
      end
      CHECK_DRAIN: begin
        if (!commit_q || collision_d) begin
          state_d = DONE;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = DONE;
        end else begin
          state_d = WRITE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    rd_addr   = {ADDR_W{1'b0}};
    wr_en     = 1'b0;
    wr_addr   = {ADDR_W{1'b0}};
    wr_data   = 3'b000;
    busy      = 1'b0;
    done      = 1'b0;
    collision = collision_q;
    case (state_q)
      CHECK: begin
        busy = 1'b1;
        if (full_s && in_bounds_s && !above_top_s) begin
          rd_addr = addr_s;
        end else begin
          rd_addr = {ADDR_W{1'b0}};
        end
      end
      CHECK_DRAIN: begin
        busy = 1'b1;
      end
      WRITE: begin
        busy = 1'b1;
        if (full_s && in_bounds_s && !above_top_s) begin
          wr_en   = 1'b1;
          wr_addr = addr_s;
          wr_data = cell_s;
        end else begin
          wr_en = 1'b0;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
